// File: rtl/ifetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational IM and
// fills the IF/ID register; handles stall, redirect/flush, misalign and halt.
module ifetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] adress,
  input  logic [31:0] instruction,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic        misalign,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    S_BOOT,
    S_RUN,
    S_HALTED
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] instr_nxt, pc4_nxt, count_nxt;
  logic        valid_nxt, halted_nxt, misalign_nxt;
  logic [31:0] pc_plus4;

  // PC+4 wraps naturally modulo 2^32
  assign pc_plus4 = pc + 32'd4;
  assign adress   = pc;

  // next-state and next-register values; everything holds by default
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    instr_nxt    = if_id_instr;
    pc4_nxt      = if_id_pc4;
    valid_nxt    = if_id_valid;
    halted_nxt   = halted;
    misalign_nxt = misalign;
    count_nxt    = fetch_count;
    unique case (state)
      S_BOOT: begin
        state_nxt = S_RUN;
      end
      S_RUN: begin
        if (redirect) begin
          instr_nxt = NOP_WORD;
          valid_nxt = 1'b0;
          if (redirect_pc[1:0] != 2'b00) begin
            misalign_nxt = 1'b1;
            halted_nxt   = 1'b1;
            state_nxt    = S_HALTED;
          end else begin
            pc_nxt = redirect_pc;
          end
        end else if (!stall) begin
          instr_nxt = instruction;
          pc4_nxt   = pc_plus4;
          valid_nxt = 1'b1;
          count_nxt = (fetch_count == '1) ? fetch_count : fetch_count + 32'd1;
          // the halt word itself is delivered downstream; only the PC freezes
          if (instruction == HALT_WORD) begin
            halted_nxt = 1'b1;
            state_nxt  = S_HALTED;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
      end
      S_HALTED: begin
        // repeating the clear on later cycles is a no-op, so no extra flag is kept
        if (!stall) begin
          instr_nxt = NOP_WORD;
          valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = S_BOOT;
      end
    endcase
  end

  // state and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_BOOT;
      pc          <= RESET_PC;
      if_id_instr <= NOP_WORD;
      if_id_pc4   <= '0;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      if_id_instr <= instr_nxt;
      if_id_pc4   <= pc4_nxt;
      if_id_valid <= valid_nxt;
      halted      <= halted_nxt;
      misalign    <= misalign_nxt;
      fetch_count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_ifetch_stage.sv
// Self-checking bench for ifetch_stage: directed scenarios plus randomized
// stall/redirect/reset traffic against a cycle-level reference model.
module tb_ifetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] adress;
  logic [31:0] instruction;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic        misalign;
  logic [31:0] fetch_count;

  logic [31:0] mem [0:63];

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // reference model state
  int          m_phase;  // 0 boot, 1 running, 2 halted
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_halted, m_mis;

  ifetch_stage #(
    .RESET_PC (32'h0000_0000),
    .HALT_WORD(32'hFFFF_FFFF),
    .NOP_WORD (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .adress     (adress),
    .instruction(instruction),
    .if_id_instr(if_id_instr),
    .if_id_pc4  (if_id_pc4),
    .if_id_valid(if_id_valid),
    .halted     (halted),
    .misalign   (misalign),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // combinational instruction memory, 64 words mirrored across the space
  assign instruction = mem[adress[7:2]];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
  endtask

  // advance the model by one clock using the inputs currently applied
  task automatic model_edge();
    logic [31:0] w;
    if (!rst_n) begin
      m_phase = 0; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0;
      m_valid = 0; m_halted = 0; m_mis = 0; m_cnt = 32'h0;
    end else if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1) begin
      w = mem[m_pc[7:2]];
      if (redirect && redirect_pc[1:0] != 2'b00) begin
        m_mis = 1; m_halted = 1; m_phase = 2; m_valid = 0; m_instr = 32'h0;
      end else if (redirect) begin
        m_pc = redirect_pc; m_valid = 0; m_instr = 32'h0;
      end else if (!stall) begin
        m_instr = w; m_pc4 = m_pc + 4; m_valid = 1;
        if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        if (w == 32'hFFFF_FFFF) begin m_halted = 1; m_phase = 2; end
        else m_pc = m_pc + 4;
      end
    end else if (!stall) begin
      m_valid = 0; m_instr = 32'h0;
    end
  endtask

  task automatic check_all();
    chk("adress",      adress,             m_pc);
    chk("if_id_instr", if_id_instr,        m_instr);
    chk("if_id_pc4",   if_id_pc4,          m_pc4);
    chk("if_id_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
    chk("halted",      {31'h0, halted},    {31'h0, m_halted});
    chk("misalign",    {31'h0, misalign},  {31'h0, m_mis});
    chk("fetch_count", fetch_count,        m_cnt);
  endtask

  // one clock: model update, edge, sample #1 later, compare everything
  task automatic step(input logic r, input logic s, input logic rd, input logic [31:0] tgt);
    rst_n = r; stall = s; redirect = rd; redirect_pc = tgt;
    model_edge();
    @(posedge clk);
    #1;
    check_all();
  endtask

  initial begin
    rst_n = 0; stall = 0; redirect = 0; redirect_pc = 0;
    m_phase = 0; m_pc = 0; m_instr = 0; m_pc4 = 0;
    m_valid = 0; m_halted = 0; m_mis = 0; m_cnt = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[16] = 32'h4444_4444;
    mem[63] = 32'h6363_6363;

    // 1/2: reset, boot, sequential fetch with a 2-cycle stall at PC=8
    @(negedge clk);
    step(0, 1, 1, 32'h80);
    chk("rst_adress", adress, 32'h0);
    chk("rst_valid", {31'h0, if_id_valid}, 32'h0);
    step(1, 1, 1, 32'h80);                 // BOOT ignores stall/redirect
    chk("boot_adress", adress, 32'h0);
    step(1, 0, 0, 0);
    chk("f1_instr", if_id_instr, 32'h11);
    step(1, 0, 0, 0);
    chk("f2_pc4", if_id_pc4, 32'h8);
    step(1, 1, 0, 0);
    step(1, 1, 0, 0);
    chk("stall_adress", adress, 32'h8);
    chk("stall_instr", if_id_instr, 32'h22);
    chk("stall_count", fetch_count, 32'd2);
    step(1, 0, 0, 0);
    chk("f3_instr", if_id_instr, 32'h33);
    chk("f3_count", fetch_count, 32'd3);

    // 3: redirect wins over simultaneous stall
    step(1, 1, 1, 32'h40);
    chk("redir_adress", adress, 32'h40);
    chk("redir_valid", {31'h0, if_id_valid}, 32'h0);
    step(1, 0, 0, 0);
    chk("redir_fetch", if_id_instr, 32'h4444_4444);
    chk("redir_pc4", if_id_pc4, 32'h44);

    // 4: misaligned redirect halts; later redirect ignored; reset recovers
    step(1, 0, 1, 32'h42);
    chk("mis_flag", {31'h0, misalign}, 32'h1);
    chk("mis_adress", adress, 32'h44);
    step(1, 0, 1, 32'h80);
    chk("mis_ignore", adress, 32'h44);
    step(0, 0, 0, 0);
    chk("mis_rst_halted", {31'h0, halted}, 32'h0);

    // 5: halt word fetched at 0x0C
    mem[3] = 32'hFFFF_FFFF;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0);
    chk("halt_instr", if_id_instr, 32'hFFFF_FFFF);
    chk("halt_pc4", if_id_pc4, 32'h10);
    chk("halt_adress", adress, 32'h0C);
    step(1, 1, 0, 0);
    chk("halt_stall_valid", {31'h0, if_id_valid}, 32'h1);
    step(1, 0, 0, 0);
    chk("halt_clear_valid", {31'h0, if_id_valid}, 32'h0);
    chk("halt_count", fetch_count, 32'd4);
    step(1, 0, 0, 0);

    // 6: PC wrap at the top of the address space, then reset under stall
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFFC);
    step(1, 0, 0, 0);
    chk("wrap_adress", adress, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);
    chk("wrap_instr", if_id_instr, 32'h6363_6363);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("midrst_count", fetch_count, 32'h0);

    // randomized traffic
    for (int i = 0; i < 64; i++)
      mem[i] = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
    for (int c = 0; c < 3000; c++) begin
      logic        r, s, rd;
      logic [31:0] t;
      r  = ($urandom_range(0, 59) != 0);
      s  = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 7) == 0);
      t  = 32'($urandom_range(0, 63)) << 2;
      if ($urandom_range(0, 9) == 0) t = t | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 24) == 0) t = 32'hFFFF_FFFC;
      step(r, s, rd, t);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
